// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and constants shared by the UART receive/transmit
//               blocks: byte-assembly state, word type and the byte-state
//               successor function used by the assembler.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [8*BYTES_PER_WORD-1:0] word_t;

    // Which byte lane the next received byte fills.
    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } byte_state_t;

    function automatic byte_state_t next_byte_state(input byte_state_t s);
        byte_state_t n;
        case (s)
            B0:      n = B1;
            B1:      n = B2;
            B2:      n = B3;
            default: n = B0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_word_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_word_buf_if
// Description : Word hand-off bus from the receive word buffer to the core
//               loader. Valid/ready handshake; transfer when both are high.
//   word_data  : head word (driven by master)
//   word_valid : head word present (driven by master)
//   word_ready : consumer accepts head word (driven by slave)
// Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_word_buf_if;
    import uart_pkg::*;

    word_t word_data;
    logic  word_valid;
    logic  word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_fifo
// Description : First-word-fall-through FIFO of word_t, depth 2**DEPTH_LOG2.
//               A push is accepted when the FIFO is not full, or when it is
//               full and a pop happens in the same cycle.
//   clk, rstn     : clock, asynchronous active-low reset
//   i_push        : push request, i_push_data is the candidate word
//   o_push_ok     : push request accepted this cycle
//   i_pop_req     : consumer ready; pops only while o_valid is high
//   o_data        : head word, zero while empty
//   o_valid       : FIFO non-empty (registered)
//   o_count       : number of stored words (registered)
// Revision    : 1.0  initial release
// ============================================================================
module uart_word_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    input  wire logic                i_push,
    input  wire word_t               i_push_data,
    output      logic                o_push_ok,
    input  wire logic                i_pop_req,
    output      word_t               o_data,
    output      logic                o_valid,
    output      logic [DEPTH_LOG2:0] o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   C_DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE   = DEPTH_LOG2'(1);

    word_t                 r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_valid;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_full  = (r_count == C_DEPTH_CNT);
    assign w_empty = ~r_valid;
    assign w_pop   = r_valid & i_pop_req;
    // When full, the slot being freed by this cycle's pop is the one written.
    assign w_push  = i_push & (~w_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage needs no reset: o_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    assign o_push_ok = w_push;
    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid   = r_valid;
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_word_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_word_buf
// Description : Packs received UART bytes little-endian into 32-bit words,
//               queues them in a FWFT FIFO and presents them on a valid/ready
//               word bus. Sticky overflow flag for words lost to a full FIFO.
//   clk, rstn    : clock, asynchronous active-low reset
//   rdata        : received byte, qualified by rdata_ready pulse
//   ferr         : framing-error level from the byte receiver
//   word_if      : word bus (master side): word_data/word_valid/word_ready
//   count        : words currently stored
//   overflow     : sticky, a completed word was dropped
//   ovf_clr      : clears overflow (and err); a same-cycle set wins
//   err          : sticky framing-error flag (only with the macro below)
// Configuration: define UART_RXBUF_FERR_DROP_EN to make a rising ferr discard
//               the partially assembled word and raise err.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_word_buf
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    input  wire logic [7:0]          rdata,
    input  wire logic                rdata_ready,
    input  wire logic                ferr,
    uart_rx_word_buf_if.master       word_if,
    output      logic [DEPTH_LOG2:0] count,
    output      logic                overflow,
`ifdef UART_RXBUF_FERR_DROP_EN
    output      logic                err,
`endif
    input  wire logic                ovf_clr
);

    byte_state_t r_state;
    logic [23:0] r_pack;
    logic        r_overflow;

    logic        w_drop;
    logic        w_byte;
    logic        w_push_req;
    logic        w_push_ok;
    word_t       w_push_word;

`ifdef UART_RXBUF_FERR_DROP_EN
    logic r_ferr_q;
    logic r_err;

    // A rising framing error abandons the word in progress, including any
    // byte that arrives in the same cycle.
    assign w_drop = ferr & ~r_ferr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ferr_q <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ferr_q <= ferr;
            if (w_drop) begin
                r_err <= 1'b1;
            end else if (ovf_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_ferr;

    assign w_drop        = 1'b0;
    assign w_unused_ferr = ferr;
`endif

    assign w_byte      = rdata_ready & ~w_drop;
    assign w_push_req  = w_byte & (r_state == B3);
    assign w_push_word = {rdata, r_pack};

    // Byte assembler: lane k of the word receives the byte seen in state Bk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= B0;
            r_pack  <= '0;
        end else if (w_drop) begin
            r_state <= B0;
            r_pack  <= '0;
        end else if (w_byte) begin
            case (r_state)
                B0:      r_pack[7:0]   <= rdata;
                B1:      r_pack[15:8]  <= rdata;
                B2:      r_pack[23:16] <= rdata;
                default: r_pack        <= r_pack;
            endcase
            r_state <= next_byte_state(r_state);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push_ok) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    uart_word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push_req),
        .i_push_data (w_push_word),
        .o_push_ok   (w_push_ok),
        .i_pop_req   (word_if.word_ready),
        .o_data      (word_if.word_data),
        .o_valid     (word_if.word_valid),
        .o_count     (count)
    );

    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_word_buf
// Description : Self-checking bench for uart_rx_word_buf (DEPTH_LOG2 = 4).
//               Expected words are queued when their last byte is driven and
//               compared whenever the DUT hands a word over.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_word_buf;

    localparam int DL2 = 4;

    logic             clk;
    logic             rstn;
    logic [7:0]       rdata;
    logic             rdata_ready;
    logic             ferr;
    logic             ovf_clr;
    logic [DL2:0]     count;
    logic             overflow;
`ifdef UART_RXBUF_FERR_DROP_EN
    logic             err;
`endif

    uart_rx_word_buf_if word_if ();

    uart_rx_word_buf #(
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rdata       (rdata),
        .rdata_ready (rdata_ready),
        .ferr        (ferr),
        .word_if     (word_if),
        .count       (count),
        .overflow    (overflow),
`ifdef UART_RXBUF_FERR_DROP_EN
        .err         (err),
`endif
        .ovf_clr     (ovf_clr)
    );

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest queued word.
    always @(negedge clk) begin
        if (rstn && word_if.word_valid && word_if.word_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", word_if.word_data, 32'hxxxxxxxx);
            end else begin
                chk("word_out", word_if.word_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic rdy);
        @(posedge clk);
        #1;
        rdata       = b;
        rdata_ready = 1'b1;
        if (rdy) word_if.word_ready = 1'b1;
        @(posedge clk);
        #1;
        rdata_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic expect_push);
        send_byte(w[7:0],   1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[23:16], 1'b0);
        if (expect_push) exp_q.push_back(w);
        send_byte(w[31:24], 1'b0);
    endtask

    task automatic drain(input int expect_pops);
        bit done;
        done = 1'b0;
        pops = 0;
        @(posedge clk);
        #1;
        word_if.word_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!word_if.word_valid && exp_q.size() == 0) done = 1'b1;
        end
        @(posedge clk);
        #1;
        word_if.word_ready = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
        end
        chk("drain_pops", 32'(pops), 32'(expect_pops));
        @(negedge clk);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_valid", 32'(word_if.word_valid), 32'd0);
        exp_q.delete();
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
        vecs[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[4] = '{8'h80, 8'h40, 8'h20, 8'h10, 32'h10204080};
        vecs[5] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};

        rstn               = 1'b0;
        rdata              = 8'h00;
        rdata_ready        = 1'b0;
        ferr               = 1'b0;
        ovf_clr            = 1'b0;
        word_if.word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid",    32'(word_if.word_valid), 32'd0);
        chk("rst_data",     word_if.word_data,       32'd0);
        chk("rst_count",    32'(count),              32'd0);
        chk("rst_overflow", 32'(overflow),           32'd0);

        // 1: slow bytes, little-endian packing, one-cycle latency
        send_byte(8'h78, 1'b0); repeat (10) @(posedge clk);
        send_byte(8'h56, 1'b0); repeat (10) @(posedge clk);
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        chk("t1_valid_partial", 32'(word_if.word_valid), 32'd0);
        repeat (10) @(posedge clk);
        exp_q.push_back(32'h12345678);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        chk("t1_valid", 32'(word_if.word_valid), 32'd1);
        chk("t1_data",  word_if.word_data,       32'h12345678);
        chk("t1_count", 32'(count),              32'd1);
        drain(1);

        // 2: fill to 16, 17th word dropped, head untouched, clear overflow
        for (int i = 0; i < 16; i++) send_word(32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b1);
        @(negedge clk);
        chk("t2_count_full", 32'(count),    32'd16);
        chk("t2_ovf_before", 32'(overflow), 32'd0);
        send_word(32'hBAD0BAD0, 1'b0);
        @(negedge clk);
        chk("t2_count",    32'(count),        32'd16);
        chk("t2_overflow", 32'(overflow),     32'd1);
        chk("t2_head",     word_if.word_data, 32'h1000_0000);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        chk("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: full FIFO, pop in same cycle as completing byte -> accepted
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        exp_q.push_back(32'h44332211);
        send_byte(8'h44, 1'b1);
        word_if.word_ready = 1'b0;
        @(negedge clk);
        chk("t3_count",    32'(count),    32'd16);
        chk("t3_overflow", 32'(overflow), 32'd0);
        drain(16);

        // 4: 20 words streamed with ready held high (table + generated)
        pops = 0;
        @(posedge clk); #1; word_if.word_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].b0, 1'b0);
            send_byte(vecs[i].b1, 1'b0);
            send_byte(vecs[i].b2, 1'b0);
            exp_q.push_back(vecs[i].exp);
            send_byte(vecs[i].b3, 1'b0);
        end
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b [4];
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
            send_byte(b[0], 1'b0);
            send_byte(b[1], 1'b0);
            send_byte(b[2], 1'b0);
            exp_q.push_back({b[3], b[2], b[1], b[0]});
            send_byte(b[3], 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t4_pops", 32'(pops), 32'd20);
        drain(0);

        // 5: reset mid-word discards partial bytes
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        @(posedge clk); #3; rstn = 1'b0;
        @(negedge clk);
        chk("t5_rst_count", 32'(count), 32'd0);
        @(posedge clk); #1; rstn = 1'b1;
        exp_q.delete();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        exp_q.push_back(32'hDDCCBBAA);
        send_byte(8'hDD, 1'b0);
        @(negedge clk);
        chk("t5_data",  word_if.word_data, 32'hDDCCBBAA);
        chk("t5_count", 32'(count),        32'd1);
        drain(1);

        // 6: framing error in the middle of a word
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        @(posedge clk); #1; ferr = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
`ifdef UART_RXBUF_FERR_DROP_EN
        send_byte(8'h33, 1'b0);
        exp_q.push_back(32'h44332211);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("t6_data",  word_if.word_data, 32'h44332211);
        chk("t6_count", 32'(count),        32'd1);
        chk("t6_err",   32'(err),          32'd1);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        chk("t6_err_clr", 32'(err), 32'd0);
`else
        exp_q.push_back(32'h22110201);
        @(negedge clk);
        chk("t6_data",  word_if.word_data, 32'h22110201);
        chk("t6_count", 32'(count),        32'd1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("t6_count_partial", 32'(count), 32'd1);
`endif
        ferr = 1'b0;
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
